// File: rtl/tff_pkg.sv
// Shared types, defaults and helpers for the T-flop counter library.
// No logic, so no latency.
// No flow control.
package tff_pkg;

  // Counter width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Behaviour of the counter when it reaches either bound.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  // Parallel-load values above the top of the count range are clamped to it.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit toggle flop with an async active-low reset to a selectable value.
// Latency: q toggles one clock after t is sampled high.
// No flow control; t=0 holds the bit.
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic rst_val,
  output logic q,
  output logic qbar
);

  // Toggle on t; reset loads the per-bit reset value immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= rst_val;
    end else if (t) begin
      q <= ~q;
    end
  end

  // Deriving qbar from q keeps it the exact complement, including during reset.
  assign qbar = ~q;

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down modulus counter built from T-flop cells with load, wrap/saturate and event flags.
// Latency: q and wrap update one clock after the sampling edge; tc is combinational.
// No flow control; en=0 holds the count, load overrides en.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam cnt_mode_e        MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic             wrap_next;

  assign ld_q = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

  // Next count: load beats enable; bound hits either wrap around or hold, and flag the event.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = ld_q;
    end else if (en) begin
      if (up_dn) begin
        if (q == MAX_Q) begin
          wrap_next = 1'b1;
          if (MODE == MODE_WRAP) q_next = '0;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          wrap_next = 1'b1;
          if (MODE == MODE_WRAP) q_next = MAX_Q;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // Each cell flips exactly the bits that differ between the current and next count.
  assign t = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .t       (t[i]),
      .rst_val (RST_Q[i]),
      .q       (q[i]),
      .qbar    (qbar[i])
    );
  end

  // Terminal count looks at the bound in the current direction, only when a count step would happen.
  assign tc = en & ~load & (up_dn ? (q == MAX_Q) : (q == '0));

  // One-cycle pulse after a wrap or a saturation hit; repeats while saturation persists.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
module tb_tff_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] lv8;
  logic [3:0] lv4;

  logic [3:0] q_a, qbar_a, q_b, qbar_b;
  logic [7:0] q_c, qbar_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;

  int nerr = 0;
  int nchk = 0;
  bit chk_on = 0;

  // Reference model state per instance: A = mod-10 wrap, B = mod-10 saturate, C = 8-bit full range.
  int m_q[3];
  int m_w[3];
  int MX[3] = '{9, 9, 255};
  int RV[3] = '{3, 3, 0};
  int SAT[3] = '{0, 1, 0};

  assign lv4 = lv8[3:0];

  tff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(3), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .q(q_a), .qbar(qbar_a), .tc(tc_a), .wrap(wrap_a));

  tff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(3), .SATURATE(1)) u_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .q(q_b), .qbar(qbar_b), .tc(tc_b), .wrap(wrap_b));

  tff_updown_counter #(.WIDTH(8)) u_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv8),
    .q(q_c), .qbar(qbar_c), .tc(tc_c), .wrap(wrap_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model straight from the counting rules, in plain integer arithmetic.
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 3; k++) begin
      int lvk;
      lvk = (k == 2) ? int'(lv8) : int'(lv8) % 16;
      if (!reset) begin
        m_q[k] = RV[k];
        m_w[k] = 0;
      end else if (load) begin
        m_q[k] = (lvk > MX[k]) ? MX[k] : lvk;
        m_w[k] = 0;
      end else if (en) begin
        m_w[k] = 0;
        if (up_dn) begin
          if (m_q[k] == MX[k]) begin
            m_w[k] = 1;
            if (SAT[k] == 0) m_q[k] = 0;
          end else begin
            m_q[k] = m_q[k] + 1;
          end
        end else begin
          if (m_q[k] == 0) begin
            m_w[k] = 1;
            if (SAT[k] == 0) m_q[k] = MX[k];
          end else begin
            m_q[k] = m_q[k] - 1;
          end
        end
      end else begin
        m_w[k] = 0;
      end
    end
  end

  function automatic int m_tc(input int k);
    if (!en || load) return 0;
    return up_dn ? int'(m_q[k] == MX[k]) : int'(m_q[k] == 0);
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("q_a", int'(q_a), m_q[0]);
      check("qbar_a", int'(qbar_a), 15 - m_q[0]);
      check("tc_a", int'(tc_a), m_tc(0));
      check("wrap_a", int'(wrap_a), m_w[0]);
      check("q_b", int'(q_b), m_q[1]);
      check("qbar_b", int'(qbar_b), 15 - m_q[1]);
      check("tc_b", int'(tc_b), m_tc(1));
      check("wrap_b", int'(wrap_b), m_w[1]);
      check("q_c", int'(q_c), m_q[2]);
      check("qbar_c", int'(qbar_c), 255 - m_q[2]);
      check("tc_c", int'(tc_c), m_tc(2));
      check("wrap_c", int'(wrap_c), m_w[2]);
    end
  end

  // Apply inputs, then return 1 time unit after the edge that consumed them.
  task automatic cyc(input logic e, input logic u, input logic l, input logic [7:0] v);
    en = e; up_dn = u; load = l; lv8 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; lv8 = 8'd0;
    for (int k = 0; k < 3; k++) begin
      m_q[k] = RV[k];
      m_w[k] = 0;
    end

    // Reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_q_a", int'(q_a), 3);
    check("rst_qbar_a", int'(qbar_a), 12);
    check("rst_wrap_a", int'(wrap_a), 0);
    check("rst_q_c", int'(q_c), 0);
    #10 reset = 1'b1;
    chk_on = 1'b1;
    @(posedge clk);
    #1;

    // Up-wrap at modulus 10 (A wraps, B saturates).
    cyc(1'b0, 1'b1, 1'b1, 8'd0);
    check("up_start_a", int'(q_a), 0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 8'd0);
    check("up_9_a", int'(q_a), 9);
    check("up_tc_a", int'(tc_a), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'd0);
    check("up_wrapq_a", int'(q_a), 0);
    check("up_wrap_a", int'(wrap_a), 1);
    check("up_satq_b", int'(q_b), 9);
    check("up_satw_b", int'(wrap_b), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'd0);
    check("up_after_a", int'(q_a), 1);
    check("up_after_w_a", int'(wrap_a), 0);

    // Down-saturate on B from a load of 2.
    cyc(1'b0, 1'b0, 1'b1, 8'd2);
    check("dn_ld_b", int'(q_b), 2);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    check("dn_1_b", int'(q_b), 1);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    check("dn_0_b", int'(q_b), 0);
    check("dn_0_w_b", int'(wrap_b), 0);
    check("dn_tc_b", int'(tc_b), 1);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    check("dn_hold1_b", int'(q_b), 0);
    check("dn_hold1_w_b", int'(wrap_b), 1);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    check("dn_hold2_b", int'(q_b), 0);
    check("dn_hold2_w_b", int'(wrap_b), 1);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    check("dn_idle_w_b", int'(wrap_b), 0);

    // Load beats enable and clamps to the top of the range.
    cyc(1'b1, 1'b1, 1'b1, 8'h0F);
    check("ld_clamp_a", int'(q_a), 9);
    check("ld_clamp_b", int'(q_b), 9);
    check("ld_wrap_a", int'(wrap_a), 0);
    check("ld_noclamp_c", int'(q_c), 15);

    // Asynchronous reset mid-count.
    cyc(1'b0, 1'b1, 1'b1, 8'd6);
    check("mid_ld_a", int'(q_a), 6);
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_q_a", int'(q_a), 3);
    check("mid_rst_qbar_a", int'(qbar_a), 12);
    check("mid_rst_w_a", int'(wrap_a), 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_resume_a", int'(q_a), 4);

    // Random mix of enable, direction and load across all three configurations.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
